aip_accum_core: RTL and testbench



---
 rtl/aip_accum_core.sv | 118 +++++++++++
 tb/tb_aip_accum_core.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/aip_accum_core.sv
// aip_accum_core: buffered burst reducer (modular SUM, XOR; MAX when ACCUM_MAX_EN) with AIP register interface
module aip_accum_core #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 16,
  parameter logic [31:0] IP_ID = 32'h0000_A5C1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [4:0]            conf_dbus,
  input  logic                  read,
  input  logic                  write,
  input  logic                  start,
  output logic                  int_req
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] A_IN = 5'h00, A_OUT = 5'h01, A_CFG = 5'h02, A_STAT = 5'h03, A_ID = 5'h1E;
`ifdef ACCUM_MAX_EN
  localparam logic [1:0] R_LAST = 2'd2;
  localparam logic MAX_BIT = 1'b1;
  logic [DATA_WIDTH-1:0] mx;
`else
  localparam logic [1:0] R_LAST = 2'd1;
  localparam logic MAX_BIT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] sum, xr, res, rd_data;
  logic [AW:0] wr_ptr, eff_len, len_cap;
  logic [AW-1:0] idx;
  logic [1:0] rd_ptr;
  logic [8:0] len;
  logic done, ovf, err, busy, go, last, wr_in;
  assign int_req = done;
  always_comb begin
    len_cap = (len >= 9'(DEPTH)) ? (AW+1)'(DEPTH) : (AW+1)'(len);
    go = start && state == IDLE;
    last = {1'b0, idx} == eff_len - (AW+1)'(1);
    wr_in = write && conf_dbus == A_IN && !busy && wr_ptr != (AW+1)'(DEPTH);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (start ? (len_cap == '0 ? DONE : RUN) : IDLE)
             : state == RUN  ? (last ? DONE : RUN) : IDLE;
  always_comb busy = state == RUN;
  always_comb begin
`ifdef ACCUM_MAX_EN
    res = rd_ptr == 2'd0 ? sum : rd_ptr == 2'd1 ? xr : mx;
`else
    res = rd_ptr == 2'd0 ? sum : xr;
`endif
    rd_data = conf_dbus == A_OUT  ? res
            : conf_dbus == A_CFG  ? DATA_WIDTH'(len)
            : conf_dbus == A_STAT ? DATA_WIDTH'({MAX_BIT, err, ovf, busy, done})
            : conf_dbus == A_ID   ? DATA_WIDTH'(IP_ID) : '0;
  end
  always_ff @(posedge clk)
    if (wr_in) mem[wr_ptr[AW-1:0]] <= data_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      len <= '0;
      sum <= '0;
      xr <= '0;
      done <= 1'b0;
      ovf <= 1'b0;
      err <= 1'b0;
      idx <= '0;
      eff_len <= '0;
`ifdef ACCUM_MAX_EN
      mx <= '0;
`endif
    end else begin
      if (read) data_out <= rd_data;
      if (read && conf_dbus == A_OUT) rd_ptr <= rd_ptr == R_LAST ? 2'd0 : rd_ptr + 2'd1;
      if (wr_in) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (write && conf_dbus == A_IN && !busy && wr_ptr == (AW+1)'(DEPTH)) ovf <= 1'b1;
      if (write && conf_dbus == A_CFG && !busy) len <= data_in[8:0];
      if (write && conf_dbus == A_STAT && data_in[0]) begin
        done <= 1'b0;
        ovf <= 1'b0;
        err <= 1'b0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
      // dropped traffic while busy is flagged after any clear so it is never lost
      if (busy && (start || (write && (conf_dbus == A_IN || conf_dbus == A_CFG)))) err <= 1'b1;
      if (go) begin
        sum <= '0;
        xr <= '0;
        done <= 1'b0;
        idx <= '0;
        eff_len <= len_cap;
`ifdef ACCUM_MAX_EN
        mx <= '0;
`endif
      end
      if (busy) begin
        sum <= sum + mem[idx];
        xr <= xr ^ mem[idx];
        idx <= idx + AW'(1);
`ifdef ACCUM_MAX_EN
        if (mem[idx] > mx) mx <= mem[idx];
`endif
      end
      if (state == DONE) begin
        done <= 1'b1;
        rd_ptr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_aip_accum_core.sv
// tb_aip_accum_core: directed and randomized checks of aip_accum_core against a burst-level model
module tb_aip_accum_core;
  localparam int DW = 32, DEPTH = 16;
`ifdef ACCUM_MAX_EN
  localparam int NRES = 3;
  localparam logic [31:0] MAXB = 32'h10;
`else
  localparam int NRES = 2;
  localparam logic [31:0] MAXB = 32'h0;
`endif
  logic clk = 0, rst = 1, read = 0, write = 0, start = 0;
  logic [4:0] conf_dbus = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic int_req;
  int checks = 0, errors = 0;
  logic [31:0] mm [DEPTH];
  logic [31:0] res_m [3];
  int wp = 0, rp = 0;

  aip_accum_core #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out), .conf_dbus(conf_dbus),
    .read(read), .write(write), .start(start), .int_req(int_req)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    conf_dbus = a; data_in = d; write = 1; tick; write = 0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    conf_dbus = a; read = 1; tick; read = 0; v = data_out;
  endtask

  task automatic rdchk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic clear;
    wr(5'h03, 32'h1);
    wp = 0; rp = 0;
  endtask

  task automatic push(input logic [31:0] d);
    if (wp < DEPTH) begin mm[wp] = d; wp++; end
    wr(5'h00, d);
  endtask

  task automatic res_chk(input string tag);
    logic [31:0] v;
    rd(5'h01, v);
    chk(tag, v, res_m[rp]);
    rp = (rp + 1) % NRES;
  endtask

  // disturb: issue a second start and a MEM_IN write while the burst is running
  task automatic run(input int len, input string tag, input bit disturb);
    int eff, n;
    eff = len < DEPTH ? len : DEPTH;
    res_m = '{default: 32'h0};
    for (int i = 0; i < eff; i++) begin
      res_m[0] += mm[i];
      res_m[1] ^= mm[i];
      if (mm[i] > res_m[2]) res_m[2] = mm[i];
    end
    wr(5'h02, 32'(len));
    start = 1; tick; start = 0;
    n = 0;
    if (disturb) begin
      start = 1; tick; start = 0;
      wr(5'h00, 32'hDEAD_BEEF);
      n = 2;
    end
    while (!int_req && n < 300) begin tick; n++; end
    chk({tag, " latency"}, 32'(n), 32'(eff + 1));
    rp = 0;
  endtask

  initial begin
    logic [31:0] v;
    bit bad;
    int n, len;
    repeat (3) tick;
    chk("reset data_out", data_out, 0);
    chk("reset int_req", {31'b0, int_req}, 0);
    rst = 0;
    rdchk("id", 5'h1E, 32'h0000_A5C1);
    rdchk("status reset", 5'h03, MAXB);
    rdchk("unmapped", 5'h07, 0);
    chk("int_req idle", {31'b0, int_req}, 0);

    for (int i = 1; i <= 4; i++) push(32'(i));
    run(4, "basic", 0);
    chk("basic sum model", res_m[0], 10);
    chk("basic xor model", res_m[1], 4);
    for (int k = 0; k <= NRES; k++) res_chk("basic result");
    rdchk("basic status", 5'h03, 32'h1 | MAXB);

    clear;
    push(32'hFFFF_FFFF); push(32'h2);
    run(2, "wrap", 0);
    res_chk("wrap sum");
    res_chk("wrap xor");
    conf_dbus = 5'h03; data_in = 1; read = 1; write = 1; tick; read = 0; write = 0;
    chk("status read before clear", data_out, 32'h1 | MAXB);
    chk("int_req cleared", {31'b0, int_req}, 0);
    rdchk("status cleared", 5'h03, MAXB);

    clear;
    for (int i = 0; i < 17; i++) push($urandom);
    rdchk("ovf status", 5'h03, 32'h4 | MAXB);
    run(20, "ovf", 1);
    res_chk("ovf sum");
    res_chk("ovf xor");
    rdchk("err status", 5'h03, 32'hD | MAXB);
    rdchk("len kept", 5'h02, 20);

    clear;
    run(0, "zero", 0);
    res_chk("zero sum");
    res_chk("zero xor");

    for (int r = 0; r < 8; r++) begin
      clear;
      n = $urandom_range(1, DEPTH);
      for (int j = 0; j < n; j++) push($urandom);
      len = $urandom_range(0, n);
      run(len, "rnd", 0);
      for (int k = 0; k <= NRES; k++) res_chk("rnd result");
      rdchk("rnd status", 5'h03, 32'h1 | MAXB);
    end

`ifdef ACCUM_MAX_EN
    clear;
    push(32'd7); push(32'h8000_0000); push(32'd3);
    run(3, "max", 0);
    chk("max model", res_m[2], 32'h8000_0000);
    for (int k = 0; k < 4; k++) res_chk("max result");
    rdchk("max status", 5'h03, 32'h11);
`endif

    clear;
    rdchk("pre-abort read", 5'h1E, 32'h0000_A5C1);
    for (int i = 0; i < 8; i++) push($urandom | 32'h1);
    wr(5'h02, 8);
    start = 1; tick; start = 0;
    tick; tick;
    rst = 1; tick; rst = 0;
    chk("abort data_out", data_out, 0);
    chk("abort int_req", {31'b0, int_req}, 0);
    bad = 0;
    repeat (12) begin tick; if (int_req !== 1'b0) bad = 1; end
    chk("abort no irq", {31'b0, bad}, 0);
    rdchk("abort status", 5'h03, MAXB);
    rdchk("abort len", 5'h02, 0);
    rdchk("abort sum", 5'h01, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
